// File: rtl/mul_share_sched.sv
// Round-robin sharing of one free-running pipelined signed multiplier among NREQ requesters.
// Each issue carries {requester id, user tag} down a pipeline matched to MUL_LAT so products route back.
module mul_share_sched #(
   parameter int NREQ    = 2,
   parameter int A_W     = 33,
   parameter int B_W     = 64,
   parameter int P_W     = 96,
   parameter int MUL_LAT = 5,
   parameter int UTAG_W  = 2
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic                   sched_en,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*A_W-1:0]    req_a,
   input  logic [NREQ*B_W-1:0]    req_b,
   input  logic [NREQ*UTAG_W-1:0] req_utag,
   output logic [A_W-1:0]         mul_din0,
   output logic [B_W-1:0]         mul_din1,
   output logic                   mul_vld,
   input  logic [P_W-1:0]         mul_dout,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [P_W-1:0]         rsp_data,
   output logic [UTAG_W-1:0]      rsp_utag,
   output logic                   idle
);

   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic              gnt_any;
   logic [ID_W-1:0]   gnt_idx;
   logic              hs;

   logic              mul_vld_q, mul_vld_d;
   logic [A_W-1:0]    mul_din0_q, mul_din0_d;
   logic [B_W-1:0]    mul_din1_q, mul_din1_d;
   logic [ID_W-1:0]   iss_id_q, iss_id_d;
   logic [UTAG_W-1:0] iss_utag_q, iss_utag_d;

   logic [MUL_LAT-1:0]             tp_vld_q, tp_vld_d;
   logic [MUL_LAT-1:0][ID_W-1:0]   tp_id_q, tp_id_d;
   logic [MUL_LAT-1:0][UTAG_W-1:0] tp_utag_q, tp_utag_d;

   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [P_W-1:0]    rsp_data_q, rsp_data_d;
   logic [UTAG_W-1:0] rsp_utag_q, rsp_utag_d;

   // Search from ptr upward, wrapping once; first valid requester wins.
   always_comb begin
      int             idx;
      logic [ID_W-1:0] cand;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      cand    = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = ID_W'(idx);
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // Reset gates the grant so req_ready reads zero while reset is held.
   assign hs        = gnt_any & sched_en & ap_rst_n;
   assign req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;

   always_comb begin
      ptr_d      = ptr_q;
      mul_vld_d  = hs;
      mul_din0_d = mul_din0_q;
      mul_din1_d = mul_din1_q;
      iss_id_d   = iss_id_q;
      iss_utag_d = iss_utag_q;
      if (hs) begin
         ptr_d      = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
         mul_din0_d = req_a[gnt_idx*A_W +: A_W];
         mul_din1_d = req_b[gnt_idx*B_W +: B_W];
         iss_id_d   = gnt_idx;
         iss_utag_d = req_utag[gnt_idx*UTAG_W +: UTAG_W];
      end
   end

   // Issue stage plus MUL_LAT tag stages lines the tail up with mul_dout.
   always_comb begin
      tp_vld_d     = tp_vld_q;
      tp_id_d      = tp_id_q;
      tp_utag_d    = tp_utag_q;
      tp_vld_d[0]  = mul_vld_q;
      tp_id_d[0]   = iss_id_q;
      tp_utag_d[0] = iss_utag_q;
      for (int i = 1; i < MUL_LAT; i++) begin
         tp_vld_d[i]  = tp_vld_q[i-1];
         tp_id_d[i]   = tp_id_q[i-1];
         tp_utag_d[i] = tp_utag_q[i-1];
      end
   end

   always_comb begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_utag_d  = rsp_utag_q;
      if (tp_vld_q[MUL_LAT-1]) begin
         rsp_valid_d = NREQ'(1) << tp_id_q[MUL_LAT-1];
         rsp_data_d  = mul_dout;
         rsp_utag_d  = tp_utag_q[MUL_LAT-1];
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ptr_q       <= '0;
         mul_vld_q   <= 1'b0;
         mul_din0_q  <= '0;
         mul_din1_q  <= '0;
         iss_id_q    <= '0;
         iss_utag_q  <= '0;
         tp_vld_q    <= '0;
         tp_id_q     <= '0;
         tp_utag_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_utag_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mul_vld_q   <= mul_vld_d;
         mul_din0_q  <= mul_din0_d;
         mul_din1_q  <= mul_din1_d;
         iss_id_q    <= iss_id_d;
         iss_utag_q  <= iss_utag_d;
         tp_vld_q    <= tp_vld_d;
         tp_id_q     <= tp_id_d;
         tp_utag_q   <= tp_utag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_utag_q  <= rsp_utag_d;
      end
   end

   assign mul_vld   = mul_vld_q;
   assign mul_din0  = mul_din0_q;
   assign mul_din1  = mul_din1_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_utag  = rsp_utag_q;
   assign idle      = ~mul_vld_q & ~(|tp_vld_q) & ~(|rsp_valid_q);

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched with a behavioural MUL_LAT-stage signed multiplier.
module tb_mul_share_sched;

   localparam int NREQ = 2, A_W = 33, B_W = 64, P_W = 96, MUL_LAT = 5, UTAG_W = 2;

   logic                   ap_clk = 1'b0;
   logic                   ap_rst_n;
   logic                   sched_en;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*A_W-1:0]    req_a;
   logic [NREQ*B_W-1:0]    req_b;
   logic [NREQ*UTAG_W-1:0] req_utag;
   logic [A_W-1:0]         mul_din0;
   logic [B_W-1:0]         mul_din1;
   logic                   mul_vld;
   logic [P_W-1:0]         mul_dout;
   logic [NREQ-1:0]        rsp_valid;
   logic [P_W-1:0]         rsp_data;
   logic [UTAG_W-1:0]      rsp_utag;
   logic                   idle;

   int n_pass = 0;
   int n_fail = 0;
   int n_chk  = 0;
   int nrsp;

   logic signed [P_W-1:0] mpipe [MUL_LAT];
   logic [P_W-1:0] exp3 [4] = '{96'd4172793605, 96'd8345587210, 96'd12518380815, 96'd16691174420};

   mul_share_sched #(
      .NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT), .UTAG_W(UTAG_W)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .sched_en(sched_en),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_utag(req_utag),
      .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_vld(mul_vld), .mul_dout(mul_dout),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_utag(rsp_utag), .idle(idle)
   );

   always #5 ap_clk = ~ap_clk;

   // Free-running multiplier, ce tied high, no reset.
   always @(posedge ap_clk) begin
      mpipe[0] <= $signed(mul_din0) * $signed(mul_din1);
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_dout = mpipe[MUL_LAT-1];

   task automatic chk(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic [UTAG_W-1:0] u);
      req_a[i*A_W +: A_W]          = a;
      req_b[i*B_W +: B_W]          = b;
      req_utag[i*UTAG_W +: UTAG_W] = u;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (idle !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("wait_idle", P_W'(idle), P_W'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst_n  = 1'b0;
      sched_en  = 1'b1;
      req_valid = 2'b11;
      req_a = '0; req_b = '0; req_utag = '0;
      set_req(0, 33'd3, -64'sd5, 2'd0);
      set_req(1, -33'sd7, 64'd11, 2'd3);
      tick();
      tick();
      @(negedge ap_clk);
      chk("rst_ready", P_W'(req_ready), '0);
      chk("rst_mul_vld", P_W'(mul_vld), '0);
      chk("rst_din0", P_W'(mul_din0), '0);
      chk("rst_din1", P_W'(mul_din1), '0);
      chk("rst_rsp_valid", P_W'(rsp_valid), '0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_rsp_utag", P_W'(rsp_utag), '0);
      chk("rst_idle", P_W'(idle), P_W'(1));
      @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;

      // Contention from reset: strict alternation starting at requester 0.
      for (int c = 0; c < 14; c++) begin
         if (c == 6) req_valid = 2'b00;
         @(negedge ap_clk);
         if (c < 6) chk("t2_ready", P_W'(req_ready), (c % 2 == 0) ? P_W'(2'b01) : P_W'(2'b10));
         if (c == 1) chk("t2_din0_r0", P_W'(mul_din0), P_W'(33'd3));
         if (c == 2) chk("t2_din0_r1", P_W'(mul_din0), P_W'(33'h1_FFFF_FFF9));
         if (c >= 7 && c < 13) begin
            if ((c - 7) % 2 == 0) begin
               chk("t2_rsp_valid", P_W'(rsp_valid), P_W'(2'b01));
               chk("t2_rsp_data", rsp_data, -96'sd15);
               chk("t2_rsp_utag", P_W'(rsp_utag), P_W'(0));
            end else begin
               chk("t2_rsp_valid", P_W'(rsp_valid), P_W'(2'b10));
               chk("t2_rsp_data", rsp_data, -96'sd77);
               chk("t2_rsp_utag", P_W'(rsp_utag), P_W'(3));
            end
         end
         if (c == 13) chk("t2_rsp_end", P_W'(rsp_valid), '0);
         tick();
      end
      wait_idle();

      // Single request, latency 7.
      for (int c = 0; c < 9; c++) begin
         if (c == 0) begin
            set_req(0, 33'd4233586, -64'sd1, 2'd1);
            req_valid = 2'b01;
         end else req_valid = 2'b00;
         @(negedge ap_clk);
         if (c == 0) chk("t1_ready", P_W'(req_ready), P_W'(2'b01));
         if (c == 1) begin
            chk("t1_mul_vld", P_W'(mul_vld), P_W'(1));
            chk("t1_din0", P_W'(mul_din0), P_W'(33'd4233586));
            chk("t1_din1", P_W'(mul_din1), P_W'(64'hFFFF_FFFF_FFFF_FFFF));
            chk("t1_idle_busy", P_W'(idle), '0);
         end
         if (c == 6) chk("t1_rsp_early", P_W'(rsp_valid), '0);
         if (c == 7) begin
            chk("t1_rsp_valid", P_W'(rsp_valid), P_W'(2'b01));
            chk("t1_rsp_data", rsp_data, -96'sd4233586);
            chk("t1_rsp_utag", P_W'(rsp_utag), P_W'(1));
            chk("t1_idle_rsp", P_W'(idle), '0);
         end
         if (c == 8) begin
            chk("t1_rsp_drop", P_W'(rsp_valid), '0);
            chk("t1_idle_after", P_W'(idle), P_W'(1));
         end
         tick();
      end
      wait_idle();

      // Requester 1 alone, back-to-back.
      for (int c = 0; c < 12; c++) begin
         if (c < 4) begin
            set_req(1, 33'd4172793605, 64'(c + 1), 2'(c));
            req_valid = 2'b10;
         end else req_valid = 2'b00;
         @(negedge ap_clk);
         if (c < 4) chk("t3_ready", P_W'(req_ready), P_W'(2'b10));
         if (c >= 7 && c < 11) begin
            chk("t3_rsp_valid", P_W'(rsp_valid), P_W'(2'b10));
            chk("t3_rsp_data", rsp_data, exp3[c-7]);
            chk("t3_rsp_utag", P_W'(rsp_utag), P_W'(c - 7));
         end
         if (c == 11) chk("t3_rsp_end", P_W'(rsp_valid), '0);
         tick();
      end
      wait_idle();

      // sched_en drops with three operations in flight.
      set_req(0, 33'd3, -64'sd5, 2'd0);
      set_req(1, -33'sd7, 64'd11, 2'd3);
      req_valid = 2'b11;
      nrsp = 0;
      for (int c = 0; c < 13; c++) begin
         sched_en = (c < 3);
         @(negedge ap_clk);
         if (c < 3) chk("t4_ready", P_W'(req_ready), (c % 2 == 0) ? P_W'(2'b01) : P_W'(2'b10));
         else chk("t4_gated", P_W'(req_ready), '0);
         if (c == 7) chk("t4_rsp0", P_W'(rsp_valid), P_W'(2'b01));
         if (c == 8) chk("t4_rsp1", P_W'(rsp_valid), P_W'(2'b10));
         if (c == 9) begin
            chk("t4_rsp2", P_W'(rsp_valid), P_W'(2'b01));
            chk("t4_idle_last", P_W'(idle), '0);
         end
         if (c == 10) chk("t4_idle_after", P_W'(idle), P_W'(1));
         if (rsp_valid != '0) nrsp++;
         tick();
      end
      chk("t4_rsp_count", P_W'(nrsp), P_W'(3));
      req_valid = 2'b00;
      sched_en  = 1'b1;
      wait_idle();

      // Reset in the middle of two in-flight operations; pointer sits at 1 beforehand.
      req_valid = 2'b11;
      @(negedge ap_clk);
      chk("t5_ready_pre", P_W'(req_ready), P_W'(2'b10));
      tick();
      tick();
      req_valid = 2'b00;
      @(negedge ap_clk);
      chk("t5_inflight", P_W'(mul_vld), P_W'(1));
      ap_rst_n  = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("t5_ready", P_W'(req_ready), '0);
      chk("t5_mul_vld", P_W'(mul_vld), '0);
      chk("t5_din0", P_W'(mul_din0), '0);
      chk("t5_din1", P_W'(mul_din1), '0);
      chk("t5_rsp_valid", P_W'(rsp_valid), '0);
      chk("t5_rsp_data", rsp_data, '0);
      chk("t5_rsp_utag", P_W'(rsp_utag), '0);
      chk("t5_idle", P_W'(idle), P_W'(1));
      tick();
      tick();
      req_valid = 2'b00;
      ap_rst_n  = 1'b1;
      nrsp = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge ap_clk);
         if (rsp_valid != '0) nrsp++;
         tick();
      end
      chk("t5_no_rsp", P_W'(nrsp), '0);
      req_valid = 2'b11;
      @(negedge ap_clk);
      chk("t5_ptr_zero", P_W'(req_ready), P_W'(2'b01));
      tick();
      req_valid = 2'b00;
      wait_idle();

      // Extreme operands; unknown operands on the idle requester must not leak.
      for (int c = 0; c < 9; c++) begin
         if (c == 0) begin
            set_req(0, 33'h1_0000_0000, 64'h8000_0000_0000_0000, 2'd2);
            req_a[A_W +: A_W] = 'x;
            req_b[B_W +: B_W] = 'x;
            req_valid = 2'b01;
         end else req_valid = 2'b00;
         @(negedge ap_clk);
         if (c == 0) chk("t6_ready", P_W'(req_ready), P_W'(2'b01));
         if (c == 1) begin
            chk("t6_din0", P_W'(mul_din0), P_W'(33'h1_0000_0000));
            chk("t6_din1", P_W'(mul_din1), P_W'(64'h8000_0000_0000_0000));
         end
         if (c == 7) begin
            chk("t6_rsp_valid", P_W'(rsp_valid), P_W'(2'b01));
            chk("t6_rsp_data", rsp_data, 96'h8000_0000_0000_0000_0000_0000);
            chk("t6_rsp_utag", P_W'(rsp_utag), P_W'(2));
         end
         tick();
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
